// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the nibble popcount sequencer.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 3;

  // Bits needed to hold any popcount of a w-bit word (0..w inclusive).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nibble_popcount_seq.sv
// Streams a word through an external 16x3 nibble-popcount ROM, LSB nibble first,
// and reports the accumulated set-bit count with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; rom_addr parked at 0
// RUN   | one ROM lookup per cycle, NIB cycles total
// DONE  | one-cycle done pulse, count freshly updated
module nibble_popcount_seq
  import popcount_pkg::*;
#(
  parameter  int WORD_W = 32,
  localparam int CNT_W  = cnt_width(WORD_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_W-1:0]     data_in,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      count
);

  localparam int NIB   = WORD_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (WORD_W < 4 || (WORD_W % 4) != 0) begin : g_bad_width
    $error("nibble_popcount_seq: WORD_W must be a multiple of 4 and >= 4");
  end

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    acc_q,   acc_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    sum;

  assign sum = acc_q + CNT_W'(rom_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Outputs decode from registered state only, so rom_addr never sees start/data_in.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    count_d  = count_q;
    rom_addr = '0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rom_addr = shreg_q[ROM_ADDR_W-1:0];
        acc_d    = sum;
        shreg_d  = shreg_q >> 4;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_W'(NIB - 1)) begin
          state_d = DONE;
          count_d = sum;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_nibble_popcount_seq.sv
// Directed and randomized checks of nibble_popcount_seq against a $countones reference.
module tb_nibble_popcount_seq;
  import popcount_pkg::*;

  localparam int WORD_W = 32;
  localparam int NIB    = WORD_W / 4;
  localparam int CNT_W  = cnt_width(WORD_W);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [WORD_W-1:0]     data_in;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [ROM_DATA_W-1:0] rom_data;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  // Nibble ROM lives outside the DUT.
  assign rom_data = ROM_DATA_W'($countones(rom_addr));

  nibble_popcount_seq #(.WORD_W(WORD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".addr"}, 32'(rom_addr), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'(exp_count));
  endtask

  // Launch one word and follow it to the IDLE cycle after done.
  // hold_start keeps start high and scrambles data_in while busy.
  task automatic do_word(input logic [WORD_W-1:0] w, input bit hold_start);
    start   = 1'b1;
    data_in = w;
    tick();
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      chk("run.busy", 32'(busy), 32'd1);
      chk("run.done", 32'(done), 32'd0);
      chk("run.addr", 32'(rom_addr), 32'((w >> (4 * i)) & 'hF));
      chk("run.count_hold", 32'(count), 32'(exp_count));
      if (hold_start) data_in = $urandom;
      tick();
    end
    exp_count = $countones(w);
    chk("done.pulse", 32'(done), 32'd1);
    chk("done.busy", 32'(busy), 32'd1);
    chk("done.count", 32'(count), 32'(exp_count));
    tick();
    chk_idle("after_done");
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #2;
    chk_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    start   = 1'b0;
    data_in = 32'hFFFF_FFFF;
    tick();
    tick();
    chk_idle("idle_no_start");

    do_word(32'hFFFF_FFFF, 1'b0);
    chk("all_ones", 32'(count), 32'd32);
    do_word(32'h1234_5678, 1'b0);
    chk("mixed", 32'(count), 32'd13);

    // Back-to-back: second start in the first IDLE cycle after done.
    do_word(32'h0000_0000, 1'b1);
    chk("zero", 32'(count), 32'd0);
    do_word(32'h8000_0001, 1'b0);
    chk("ends", 32'(count), 32'd2);

    // start held high across the whole operation; captured word must win.
    do_word(32'hA5A5_0F0F, 1'b1);
    do_word(32'h0000_00FF, 1'b0);

    // Reset in RUN cycle 4 of an all-ones word.
    start   = 1'b1;
    data_in = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst.busy", 32'(busy), 32'd1);
    chk("pre_rst.addr", 32'(rom_addr), 32'hF);
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    chk_idle("mid_reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 2; i++) begin
      chk_idle("after_abort");
      tick();
    end
    do_word(32'h0F0F_0F0F, 1'b0);
    chk("after_abort_word", 32'(count), 32'd16);

    for (int n = 0; n < 12; n++) begin
      do_word(WORD_W'($urandom), bit'(n % 3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
